// File: rtl/histogram_pkg.sv
// Shared defaults, data width and FSM state encoding for the histogram controller.
package histogram_pkg;

    localparam int DEFAULT_NUMBER_OF_PIXELS   = 16384;
    localparam int DEFAULT_NUMBER_OF_BINS     = 8;
    localparam int DEFAULT_PIXELS_PER_ADDRESS = 4;
    localparam int DEFAULT_COUNT_WIDTH        = 16;
    localparam int HISTOGRAM_DATA_WIDTH       = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        READ     = 3'd2,
        DRAIN    = 3'd3,
        WRITE    = 3'd4,
        TRANSMIT = 3'd5,
        RELEASE  = 3'd6
    } hc_state_e;

endpackage

// File: rtl/histogram_controller_pixel_bin_decoder.sv
// Maps one RAM word of 8-bit pixels to a per-bin pixel count; the bin is the top bits of each pixel.
module pixel_bin_decoder #(
    parameter int  NUMBER_OF_BINS     = 8,
    parameter int  PIXELS_PER_ADDRESS = 4,
    localparam int BIN_BITS           = $clog2(NUMBER_OF_BINS),
    localparam int INC_WIDTH          = $clog2(PIXELS_PER_ADDRESS) + 1
) (
    input  logic [8*PIXELS_PER_ADDRESS-1:0]             word,
    output logic [NUMBER_OF_BINS-1:0][INC_WIDTH-1:0]    inc
);

    always_comb begin
        inc = '0;
        for (int p = 0; p < PIXELS_PER_ADDRESS; p++) begin
            for (int b = 0; b < NUMBER_OF_BINS; b++) begin
                if ((word[8*p +: 8] >> (8 - BIN_BITS)) == 8'(b)) begin
                    inc[b] = inc[b] + INC_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/histogram_controller.sv
// Sequences one histogram per received image: clear, sweep the image RAM, write bins out, pulse transmit.
module histogram_controller
    import histogram_pkg::*;
#(
    parameter int  NUMBER_OF_PIXELS   = DEFAULT_NUMBER_OF_PIXELS,
    parameter int  NUMBER_OF_BINS     = DEFAULT_NUMBER_OF_BINS,
    parameter int  PIXELS_PER_ADDRESS = DEFAULT_PIXELS_PER_ADDRESS,
    parameter int  COUNT_WIDTH        = DEFAULT_COUNT_WIDTH,
    localparam int DEPTH              = NUMBER_OF_PIXELS / PIXELS_PER_ADDRESS,
    localparam int ADDR_WIDTH         = $clog2(DEPTH),
    localparam int BIN_BITS           = $clog2(NUMBER_OF_BINS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              image_received,
    output logic [ADDR_WIDTH-1:0]             image_data_address,
    input  logic [8*PIXELS_PER_ADDRESS-1:0]   image_data_in,
    output logic                              histogram_write_enable,
    output logic [BIN_BITS-1:0]               histogram_write_address,
    output logic [HISTOGRAM_DATA_WIDTH-1:0]   histogram_data,
    output logic                              histogram_transmit,
    output logic                              busy,
    output hc_state_e                         debug_state
);

    localparam int INC_WIDTH = $clog2(PIXELS_PER_ADDRESS) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [BIN_BITS-1:0]   LAST_BIN  = BIN_BITS'(NUMBER_OF_BINS - 1);

    hc_state_e                               state, state_next;
    logic [ADDR_WIDTH-1:0]                   addr;
    logic                                    rd_valid;
    logic [BIN_BITS-1:0]                     bin_idx;
    logic [NUMBER_OF_BINS-1:0][INC_WIDTH-1:0] inc;
    logic [COUNT_WIDTH-1:0]                  counts     [NUMBER_OF_BINS];
    logic [COUNT_WIDTH-1:0]                  counts_sum [NUMBER_OF_BINS];
    logic                                    wr_active;

    pixel_bin_decoder #(
        .NUMBER_OF_BINS     (NUMBER_OF_BINS),
        .PIXELS_PER_ADDRESS (PIXELS_PER_ADDRESS)
    ) u_decoder (
        .word (image_data_in),
        .inc  (inc)
    );

    // Saturating add: the carry-out of the widened sum selects all-ones.
    always_comb begin
        logic [COUNT_WIDTH:0] wide;
        wide = '0;
        for (int b = 0; b < NUMBER_OF_BINS; b++) begin
            wide          = {1'b0, counts[b]} + (COUNT_WIDTH + 1)'(inc[b]);
            counts_sum[b] = wide[COUNT_WIDTH] ? '1 : wide[COUNT_WIDTH-1:0];
        end
    end

    // Any drop of image_received mid-computation abandons the image.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (image_received) state_next = CLEAR;
            CLEAR:    state_next = image_received ? READ : IDLE;
            READ: begin
                if (!image_received)        state_next = IDLE;
                else if (addr == LAST_ADDR) state_next = DRAIN;
            end
            DRAIN:    state_next = image_received ? WRITE : IDLE;
            WRITE: begin
                if (!image_received)         state_next = IDLE;
                else if (bin_idx == LAST_BIN) state_next = TRANSMIT;
            end
            TRANSMIT: state_next = RELEASE;
            RELEASE:  if (!image_received) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            rd_valid <= 1'b0;
            bin_idx  <= '0;
        end else begin
            state    <= state_next;
            rd_valid <= (state == READ) && image_received;
            case (state)
                CLEAR: begin
                    addr    <= '0;
                    bin_idx <= '0;
                end
                READ:  if (addr != LAST_ADDR) addr <= addr + ADDR_WIDTH'(1);
                WRITE: bin_idx <= bin_idx + BIN_BITS'(1);
                default: ;
            endcase
        end
    end

    // Counters are deliberately outside reset; CLEAR zeroes them at the start of each image.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUMBER_OF_BINS; b++) begin
            if (state == CLEAR) begin
                counts[b] <= '0;
            end else if (rd_valid && (state == READ || state == DRAIN)) begin
                counts[b] <= counts_sum[b];
            end
        end
    end

    assign wr_active               = (state == WRITE) && image_received;
    assign histogram_write_enable  = wr_active;
    assign histogram_write_address = wr_active ? bin_idx : '0;
    assign histogram_data          = wr_active ? HISTOGRAM_DATA_WIDTH'(counts[bin_idx]) : '0;
    assign histogram_transmit      = (state == TRANSMIT);
    assign busy                    = (state != IDLE);
    assign image_data_address      = addr;
    assign debug_state             = state;

endmodule

// File: tb/tb_histogram_controller.sv
// Bench for histogram_controller: a default-parameter instance and a small saturating instance, checked against a pixel-counting model.
module tb_histogram_controller;
    import histogram_pkg::*;

    localparam int DEPTH0 = 4096;
    localparam int DEPTH1 = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ir = 2'b00;

    logic [11:0] addr0;
    logic [7:0]  addr1;
    logic [31:0] rdata0 = '0, rdata1 = '0;
    logic        we0, we1, tx0, tx1, busy0, busy1;
    logic [2:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    hc_state_e   st0, st1;

    logic [31:0] mem0 [DEPTH0];
    logic [31:0] mem1 [DEPTH1];

    logic [18:0] wr_q0[$], wr_q1[$];
    logic [18:0] exp_q[$];
    int          tx_cnt[2];
    int          tx_at[2];
    int          neg_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    histogram_controller dut0 (
        .clk(clk), .reset(reset), .image_received(ir[0]),
        .image_data_address(addr0), .image_data_in(rdata0),
        .histogram_write_enable(we0), .histogram_write_address(wa0),
        .histogram_data(wd0), .histogram_transmit(tx0), .busy(busy0),
        .debug_state(st0)
    );

    histogram_controller #(.NUMBER_OF_PIXELS(1024), .COUNT_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .image_received(ir[1]),
        .image_data_address(addr1), .image_data_in(rdata1),
        .histogram_write_enable(we1), .histogram_write_address(wa1),
        .histogram_data(wd1), .histogram_transmit(tx1), .busy(busy1),
        .debug_state(st1)
    );

    // clock / reset block and RAM models (one-cycle read latency)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata0 <= mem0[addr0];
        rdata1 <= mem1[addr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: captures bin writes and transmit pulses on the falling edge.
    always @(negedge clk) begin
        neg_cnt++;
        if (we0) wr_q0.push_back({wa0, wd0});
        if (we1) wr_q1.push_back({wa1, wd1});
        if (tx0) begin tx_cnt[0]++; tx_at[0] = neg_cnt; end
        if (tx1) begin tx_cnt[1]++; tx_at[1] = neg_cnt; end
        if (we0 || tx0) chk("excl0", {31'd0, we0 & tx0}, 32'd0);
        if (we1 || tx1) chk("excl1", {31'd0, we1 & tx1}, 32'd0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int id);
        return (id == 0) ? busy0 : busy1;
    endfunction

    // Reference: count every pixel into bin = pixel / 32, saturating at the counter maximum.
    task automatic build_expected(input int id);
        int depth, maxc, b;
        int cnt[8];
        logic [31:0] w;
        depth = (id == 0) ? DEPTH0 : DEPTH1;
        maxc  = (id == 0) ? 65535 : 255;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int i = 0; i < depth; i++) begin
            w = (id == 0) ? mem0[i] : mem1[i];
            for (int p = 0; p < 4; p++) begin
                b = int'(w[8*p +: 8]) / 32;
                if (cnt[b] < maxc) cnt[b]++;
            end
        end
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 16'(cnt[i])});
    endtask

    task automatic full_run(input int id, input string tag);
        int depth, start, k;
        logic [18:0] got[$];
        depth = (id == 0) ? DEPTH0 : DEPTH1;
        build_expected(id);
        wr_q0.delete();
        wr_q1.delete();
        tx_cnt[id] = 0;
        ir[id] = 1'b1;
        start = neg_cnt;
        k = 0;
        while (tx_cnt[id] == 0 && k < depth + 100) begin
            step();
            k++;
        end
        chk({tag, "_tx_seen"}, 32'(tx_cnt[id]), 32'd1);
        chk({tag, "_latency"}, 32'(tx_at[id] - start), 32'(depth + 11));
        if (id == 0) got = wr_q0; else got = wr_q1;
        chk({tag, "_nwrites"}, 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_bin%0d", tag, i),
                (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
        end
        repeat (10) step();
        chk({tag, "_no_rerun"}, 32'(tx_cnt[id]), 32'd1);
        chk({tag, "_release_busy"}, {31'd0, busy_of(id)}, 32'd1);
        ir[id] = 1'b0;
        step();
        step();
        chk({tag, "_idle_busy"}, {31'd0, busy_of(id)}, 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < DEPTH0; i++) mem0[i] = '0;
        for (int i = 0; i < DEPTH1; i++) mem1[i] = '0;
        tx_cnt[0] = 0; tx_cnt[1] = 0;
        tx_at[0] = 0;  tx_at[1] = 0;

        // reset state
        repeat (3) step();
        chk("rst_we", {31'd0, we0}, 32'd0);
        chk("rst_tx", {31'd0, tx0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_data", 32'(wd0), 32'd0);
        chk("rst_state", 32'(st0), 32'(IDLE));
        reset = 1'b0;
        step();

        full_run(0, "zeros");

        for (int i = 0; i < DEPTH0; i++) mem0[i] = 32'hE060_2000;
        full_run(0, "spread");

        for (int i = 0; i < DEPTH0; i++) mem0[i] = (i % 2 == 0) ? 32'h403F_201F : 32'h00FF_E0DF;
        full_run(0, "bounds");

        for (int i = 0; i < DEPTH0; i++) mem0[i] = $urandom();
        full_run(0, "rand");

        for (int i = 0; i < DEPTH0; i++)
            for (int p = 0; p < 4; p++) mem0[i][8*p +: 8] = 8'($urandom_range(96, 159));
        full_run(0, "skew");

        for (int i = 0; i < DEPTH1; i++) mem1[i] = 32'h0505_0505;
        full_run(1, "sat");

        for (int i = 0; i < DEPTH1; i++)
            for (int p = 0; p < 4; p++) mem1[i][8*p +: 8] = 8'($urandom_range(0, 79));
        full_run(1, "sat_rand");

        // abort during READ at address 100
        for (int i = 0; i < DEPTH0; i++) mem0[i] = $urandom();
        wr_q0.delete();
        tx_cnt[0] = 0;
        ir[0] = 1'b1;
        k = 0;
        while (!(st0 == READ && addr0 == 12'd100) && k < 500) begin step(); k++; end
        chk("abort_reached", 32'(addr0), 32'd100);
        ir[0] = 1'b0;
        step();
        chk("abort_state", 32'(st0), 32'(IDLE));
        repeat (20) step();
        chk("abort_writes", 32'(wr_q0.size()), 32'd0);
        chk("abort_tx", 32'(tx_cnt[0]), 32'd0);
        full_run(0, "after_abort");

        // reset while bin 3 is being written
        for (int i = 0; i < DEPTH0; i++) mem0[i] = $urandom();
        wr_q0.delete();
        tx_cnt[0] = 0;
        ir[0] = 1'b1;
        k = 0;
        while (!(we0 && wa0 == 3'd3) && k < DEPTH0 + 100) begin step(); k++; end
        chk("wrst_reached", {29'd0, wa0}, 32'd3);
        reset = 1'b1;
        ir[0] = 1'b0;
        step();
        chk("wrst_we", {31'd0, we0}, 32'd0);
        chk("wrst_wa", 32'(wa0), 32'd0);
        chk("wrst_wd", 32'(wd0), 32'd0);
        chk("wrst_busy", {31'd0, busy0}, 32'd0);
        chk("wrst_addr", 32'(addr0), 32'd0);
        chk("wrst_state", 32'(st0), 32'(IDLE));
        reset = 1'b0;
        repeat (20) step();
        chk("wrst_tx", 32'(tx_cnt[0]), 32'd0);
        chk("wrst_writes", 32'(wr_q0.size()), 32'd4);
        full_run(0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
